// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side packing path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

  // Width of one FIFO entry (one lane of a packed word).
  localparam int DATA_WIDTH   = 8;
  // Default number of lanes gathered into one output word.
  localparam int PACK_DEFAULT = 4;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    FLUSH
  } pack_state_e;

endpackage

// File: rtl/fifo_out_reg.sv
// Single-entry valid/ready output register for the packer.
// Latency: 1 cycle from in_vld to out_valid.
// Backpressure: out_* are held stable while out_valid && !out_ready; free = !out_valid || out_ready.
//
// Ports:
//   clk_rd, rst_n            clock, async active-low reset
//   in_vld, in_dat, in_keep  load strobe and word (caller asserts in_vld only while free)
//   free                     register can take a word this cycle
//   out_valid/out_data/out_keep/out_ready  downstream valid/ready interface
module fifo_out_reg #(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic         clk_rd,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic [K-1:0] in_keep,
  output logic         free,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [K-1:0] out_keep,
  input  logic         out_ready
);

  assign free = !out_valid || out_ready;

  // Data/keep only change on a load, so they cannot move while stalled.
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (in_vld) begin
      out_valid <= 1'b1;
      out_data  <= in_dat;
      out_keep  <= in_keep;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from an async FIFO read port and packs PACK of them into one word; flush emits a partial word.
// Latency: first word valid PACK+1 cycles after the first pop; sustains one word per PACK cycles.
// Backpressure: out_ready stall holds the word stable; a second completed word parks in HOLD and pops stop.
//
// Ports:
//   clk_rd, rst_n                  read-domain clock, async active-low reset
//   fifo_empty, fifo_rd_en, fifo_rdata  FIFO read port (rdata valid 1 cycle after an accepted pop)
//   flush, flush_done              partial-word flush request / completion pulse
//   out_data, out_keep, out_valid, out_ready  packed word output, lane 0 in the low bits
//   word_cnt, stall_cnt            saturating statistics, present only with FIFO_RD_PACKER_STATS_EN
module fifo_rd_packer #(
  parameter  int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter  int PACK       = fifo_pkg::PACK_DEFAULT,
  localparam int OUT_WIDTH  = DATA_WIDTH * PACK
) (
  input  logic                  clk_rd,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FIFO_RD_PACKER_STATS_EN
  ,
  output logic [15:0]           word_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  import fifo_pkg::*;

  localparam int CW = $clog2(PACK + 1);  // lane counter, holds 0..PACK
  localparam int IW = $clog2(PACK);      // lane index

  pack_state_e           state;
  logic [CW-1:0]         lane_cnt;
  logic                  inflight;
  logic                  flush_pend;
  logic [DATA_WIDTH-1:0] lanes [PACK];

  logic                  out_free;
  logic                  xfer;
  logic                  room;
  logic                  completing;
  logic [CW:0]           cnt_sum;
  logic [OUT_WIDTH-1:0]  word_dat;
  logic [PACK-1:0]       word_keep;

  // Lanes occupied once the byte currently on fifo_rdata (if any) is counted.
  assign cnt_sum    = {1'b0, lane_cnt} + {{CW{1'b0}}, inflight};
  assign room       = cnt_sum < (CW+1)'(PACK);
  // Last lane of the word lands this cycle; the word is built straight from
  // fifo_rdata so the slot frees in time for the next back-to-back pop.
  assign completing = inflight && (lane_cnt == CW'(PACK - 1));

  // A pop is also allowed on the completing cycle when the word leaves at once,
  // unless a flush is arriving (the flush must see an empty lane set).
  assign fifo_rd_en = rst_n && !fifo_empty && (state == FILL) &&
                      (room || (completing && out_free && !flush));

  // Word view including the landing byte; unused lanes read as zero.
  always_comb begin
    word_dat  = '0;
    word_keep = '0;
    for (int i = 0; i < PACK; i++) begin
      if ((CW+1)'(i) < cnt_sum) begin
        word_keep[i] = 1'b1;
        if (inflight && (CW'(i) == lane_cnt))
          word_dat[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
        else
          word_dat[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
      end
    end
  end

  always_comb begin
    xfer = 1'b0;
    unique case (state)
      FILL:    xfer = completing && out_free;
      HOLD:    xfer = out_free;
      FLUSH:   xfer = !inflight && (lane_cnt != '0) && out_free;
      default: xfer = 1'b0;
    endcase
  end

  always_ff @(posedge clk_rd) begin
    if (inflight)
      lanes[lane_cnt[IW-1:0]] <= fifo_rdata;
  end

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      lane_cnt   <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      flush_done <= 1'b0;
      if (inflight)
        lane_cnt <= lane_cnt + CW'(1);

      case (state)
        FILL: begin
          if (completing) begin
            if (out_free) begin
              lane_cnt <= '0;
              if (flush)
                state <= FLUSH;
            end else begin
              state      <= HOLD;
              flush_pend <= flush;
            end
          end else if (flush) begin
            state <= FLUSH;
          end
        end
        HOLD: begin
          if (flush)
            flush_pend <= 1'b1;
          if (out_free) begin
            lane_cnt   <= '0;
            flush_pend <= 1'b0;
            state      <= (flush || flush_pend) ? FLUSH : FILL;
          end
        end
        FLUSH: begin
          // Wait for the landing byte so it is part of the partial word.
          if (!inflight && ((lane_cnt == '0) || out_free)) begin
            flush_done <= 1'b1;
            lane_cnt   <= '0;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  fifo_out_reg #(
    .W (OUT_WIDTH),
    .K (PACK)
  ) u_out_reg (
    .clk_rd    (clk_rd),
    .rst_n     (rst_n),
    .in_vld    (xfer),
    .in_dat    (word_dat),
    .in_keep   (word_keep),
    .free      (out_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_ready (out_ready)
  );

`ifdef FIFO_RD_PACKER_STATS_EN
  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && out_ready && (word_cnt != 16'hFFFF))
        word_cnt <= word_cnt + 16'd1;
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read port.
// Latency: n/a.
// Backpressure: out_ready is driven directly by the stimulus.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int OW = DW * PK;

  logic          clk_rd = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic          flush;
  logic          flush_done;
  logic [OW-1:0] out_data;
  logic [PK-1:0] out_keep;
  logic          out_valid;
  logic          out_ready;

  always #10 clk_rd = ~clk_rd;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk_rd     (clk_rd),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .flush      (flush),
    .flush_done (flush_done),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // FIFO model: read data appears the cycle after an accepted pop.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk_rd) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rd_while_empty = 0;
  int fd_cnt = 0;
  int first_pop_cyc = 0;
  int first_vld_cyc = 0;
  bit pop_seen = 1'b0;
  bit vld_seen = 1'b0;
  logic [PK+OW-1:0] out_q [$];
  int               hs_q  [$];

  always @(posedge clk_rd) cyc <= cyc + 1;

  // Observe at the falling edge; a handshake seen here completes at the next rising edge.
  always @(negedge clk_rd) begin
    if (fifo_rd_en && fifo_empty) rd_while_empty++;
    if (fifo_rd_en && !fifo_empty && !pop_seen) begin pop_seen = 1'b1; first_pop_cyc = cyc; end
    if (out_valid && !vld_seen) begin vld_seen = 1'b1; first_vld_cyc = cyc; end
    if (out_valid && out_ready && rst_n) begin
      out_q.push_back({out_keep, out_data});
      hs_q.push_back(cyc);
    end
    if (flush_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rd);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_flush();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    for (int i = 0; i < 40 && out_q.size() < n; i++) tick();
    chk(tag, 64'(out_q.size()), 64'(n));
  endtask

  task automatic expect_word(input string tag, input logic [OW-1:0] d, input logic [PK-1:0] k);
    logic [PK+OW-1:0] w;
    if (out_q.size() > 0) begin
      w = out_q.pop_front();
      chk(tag, 64'(w), 64'({k, d}));
    end else begin
      chk({tag, "_missing"}, 64'(out_q.size()), 64'd1);
    end
  endtask

  task automatic wait_fd(input string tag, input int fd0);
    for (int i = 0; i < 20 && fd_cnt == fd0; i++) tick();
    repeat (3) tick();
    chk(tag, 64'(fd_cnt - fd0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #5;
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_keep",   64'(out_keep),   64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_rd_en",      64'(fifo_rd_en), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Two full words back to back, ready held high.
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words("t1_count", 2);
    expect_word("t1_word0", 32'h04030201, 4'hF);
    expect_word("t1_word1", 32'h08070605, 4'hF);
    chk("t1_latency",  64'(first_vld_cyc - first_pop_cyc), 64'(PK + 1));
    if (hs_q.size() >= 2) chk("t1_interval", 64'(hs_q[1] - hs_q[0]), 64'(PK));
    else                  chk("t1_interval_missing", 64'(hs_q.size()), 64'd2);
    hs_q.delete();

    // Stalled output must stay stable; a second word parks in HOLD.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_rd); #1;
      chk("t2_stable_data", 64'({out_valid, out_keep, out_data}), 64'({1'b1, 4'hF, 32'hA3A2A1A0}));
    end
    tick();
    for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
    repeat (12) tick();
    @(negedge clk_rd); #1;
    chk("t2_hold_state", 64'(dut.state), 64'(HOLD));
    chk("t2_hold_no_pop", 64'(fifo_rd_en), 64'd0);
    chk("t2_b4_not_popped", 64'(fifo_empty), 64'd0);
    chk("t2_still_a", 64'(out_data), 64'h00000000A3A2A1A0);
    tick();
    out_ready = 1'b1;
    wait_words("t2_count", 2);
    expect_word("t2_word_a", 32'hA3A2A1A0, 4'hF);
    expect_word("t2_word_b", 32'hB3B2B1B0, 4'hF);
    repeat (4) tick();
    fd0 = fd_cnt;
    do_flush();
    wait_fd("t2_flush_done", fd0);
    expect_word("t2_word_b4", 32'h000000B4, 4'b0001);

    // Three bytes then empty: nothing until flush, then a 3-lane word.
    push(8'h11); push(8'h22); push(8'h33);
    repeat (10) tick();
    chk("t3_no_partial", 64'(out_q.size()), 64'd0);
    fd0 = fd_cnt;
    do_flush();
    wait_fd("t3_flush_done", fd0);
    expect_word("t3_partial", 32'h00332211, 4'b0111);

    // Flush in the same cycle a pop is accepted: the landing byte is kept.
    push(8'h44);
    repeat (5) tick();
    push(8'h55);
    flush = 1'b1;
    #1;
    chk("t4_pop_with_flush", 64'(fifo_rd_en), 64'd1);
    fd0 = fd_cnt;
    tick();
    flush = 1'b0;
    wait_fd("t4_flush_done", fd0);
    expect_word("t4_partial", 32'h00005544, 4'b0011);

    // Flush with no lanes held: done pulse only.
    repeat (3) tick();
    fd0 = fd_cnt;
    do_flush();
    tick();
    @(negedge clk_rd); #1;
    chk("t5_done_in_2", 64'(fd_cnt - fd0), 64'd1);
    repeat (4) tick();
    chk("t5_no_word", 64'(out_q.size()), 64'd0);

    // Reset mid-word with two lanes held.
    push(8'hC0); push(8'hC1);
    repeat (5) tick();
    rst_n = 1'b0;
    push(8'hD0);
    #2;
    chk("t6_rst_valid", 64'(out_valid),  64'd0);
    chk("t6_rst_data",  64'(out_data),   64'd0);
    chk("t6_rst_keep",  64'(out_keep),   64'd0);
    chk("t6_rst_done",  64'(flush_done), 64'd0);
    chk("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3);
    wait_words("t6_count", 1);
    expect_word("t6_clean_word", 32'hD3D2D1D0, 4'hF);

    repeat (5) tick();
    chk("rd_en_while_empty", 64'(rd_while_empty), 64'd0);
    chk("no_extra_words", 64'(out_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-domain consumer placed directly downstream of the async FIFO's read port. It pops bytes whenever the FIFO is non-empty and there is room, and accounts for the FIFO's 1-cycle read latency. It packs PACK consecutive bytes into one wide word and presents that word on a valid/ready output interface. A flush request emits any partial word with a byte-keep mask.

Parameters:
DATA_WIDTH, 8, FIFO data width (bits per lane)
PACK, 4, lanes per output word; legal range 2..8
OUT_WIDTH (localparam), DATA_WIDTH*PACK, output word width

Ports:
clk_rd  in  1  read-domain clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
fifo_empty  in  1  FIFO empty flag, read domain
fifo_rd_en  out  1  FIFO pop request
fifo_rdata  in  DATA_WIDTH  FIFO read data, valid 1 cycle after an accepted pop
flush  in  1  1-cycle pulse; emit partial word
flush_done  out  1  1-cycle pulse when flush completes
out_data  out  OUT_WIDTH  packed word; lane 0 (first byte) in [DATA_WIDTH-1:0]
out_keep  out  PACK  lane-valid mask, contiguous from lane 0
out_valid  out  1  output word valid
out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): fifo_rd_en=0, out_valid=0, out_data=0, out_keep=0, flush_done=0, lane_cnt=0, inflight=0, state=FILL.
- A pop is accepted when fifo_rd_en && !fifo_empty.
  - fifo_rd_en is combinational: !fifo_empty && state==FILL && (lane_cnt + inflight) < PACK.
  - fifo_rd_en never asserts while empty.
- inflight (1 bit) is set on the cycle of an accepted pop. The next cycle fifo_rdata is written to lane[lane_cnt] and lane_cnt increments.
- Output register holds one word and is "free" when !out_valid || out_ready.
- States:
  - FILL: issue pops.
    - When lane_cnt reaches PACK with no pop in flight: if the output register is free, transfer the word with keep all-ones, set out_valid, clear lane_cnt, stay in FILL. Otherwise go to HOLD.
  - HOLD: no pops. When the output register is free, transfer the word and return to FILL.
  - FLUSH: no new pops. Wait for inflight=0 (the landing byte is kept).
    - If lane_cnt>0: once the output register is free, transfer with out_keep = (1<<lane_cnt)-1. Unused lanes are 0.
    - If lane_cnt==0: emit nothing.
    - Then pulse flush_done, clear lane_cnt, return to FILL.
- Throughput: back-to-back pops are sustained. With out_ready held 1 and the FIFO non-empty, one word is produced every PACK cycles. First-word latency from the first pop is PACK+1 cycles.
- out_valid/out_data/out_keep stay stable while out_valid && !out_ready (AXI-style; no combinational path ready->valid).
- Flush rules:
  - Flush in FILL or HOLD: latched; the move to FLUSH happens after any pending full-word transfer.
  - Flush while in FLUSH: ignored.
  - Flush in the same cycle a word completes: the full word goes out first, then flush with lane_cnt=0, which gives flush_done with no extra word.
- FIFO empty mid-word: pack stalls indefinitely. No timeout, no partial emit without flush.
- Reset mid-operation discards the partial word and any in-flight byte. Any data popped from the FIFO is lost.

Optional Feature:
FIFO_RD_PACKER_STATS_EN
- Defined: adds two outputs, each saturating at 16'hFFFF and cleared by reset:
  - word_cnt [15:0]: increments on each out_valid&&out_ready.
  - stall_cnt [15:0]: increments each cycle out_valid && !out_ready.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH constant (reuse the existing one).
  - PACK default.
  - typedef enum logic [1:0] {FILL, HOLD, FLUSH} pack_state_e.
- One natural sub-module: fifo_out_reg, a single-entry valid/ready output register with stable-while-stalled guarantee. Instantiated once.

Test Plan:
- FIFO preloaded with 0x01..0x08, out_ready=1 -> two words, 0x04030201 then 0x08070605, out_keep=4'hF. fifo_rd_en is never high while fifo_empty=1.
- 4 bytes 0xA0..0xA3, out_ready=0 for 10 cycles -> word 0xA3A2A1A0 stable for all 10 cycles. After the next 4 bytes complete: state=HOLD and fifo_rd_en=0 until out_ready=1.
- 3 bytes 0x11,0x22,0x33 then FIFO empty, flush pulse -> out_data=0x00332211, out_keep=4'b0111, then one flush_done pulse.
- Flush pulse on the cycle a pop is accepted (byte 0x55, lane_cnt=1 holding 0x44) -> partial 0x00005544, keep=4'b0011. The in-flight byte is not lost.
- Flush with lane_cnt=0 -> no out_valid, flush_done within 2 cycles.
- Async reset asserted mid-word with 2 bytes held -> all outputs 0 immediately. After release, the next 4 bytes form a clean word with no stale lanes.
